f_fetch_ctrl: RTL

- F-stage fetch sequencer for the 5-stage MIPS pipeline.
- Owns the F_PC register and consumes the next-PC value produced by the D-stage next-PC logic.
- Drives a req/ack handshake to a multi-cycle instruction memory and holds the fetched word until decode accepts it.
- Buffers a flush redirect (exception entry / eret) that arrives while a memory request is in flight.

---
 rtl/f_fetch_ctrl_pkg.sv | 12 +
 rtl/f_fetch_ctrl_addr_chk.sv | 13 +
 rtl/f_fetch_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/f_fetch_ctrl_pkg.sv
// Shared constants for the F-stage fetch sequencer: FSM encodings and default fetch window.
package f_fetch_ctrl_pkg;

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] HOLD  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] PC_LO_DEF    = 32'h0000_3000;
   localparam logic [31:0] PC_HI_DEF    = 32'h0000_6FFC;

endpackage

// File: rtl/f_fetch_ctrl_addr_chk.sv
// Combinational word-address check: flags misaligned or out-of-window addresses.
module f_pc_addr_chk (
   input  logic [31:0] addr_i,
   input  logic [31:0] lo_i,
   input  logic [31:0] hi_i,
   output logic        fault_o
);

   always_comb begin
      fault_o = (addr_i[1:0] != 2'b00) || (addr_i < lo_i) || (addr_i > hi_i);
   end

endmodule

// File: rtl/f_fetch_ctrl.sv
// F-stage fetch sequencer: owns F_PC, runs the imem req/ack handshake, holds the word for decode.
// Optional performance counters are enabled with `define F_FETCH_PERF_EN.
module f_fetch_ctrl
   import f_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] PC_LO    = PC_LO_DEF,
   parameter logic [31:0] PC_HI    = PC_HI_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] F_newPC,
   input  logic        D_stall,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ack,
   input  logic [31:0] im_rdata,
   output logic [31:0] F_PC,
   output logic [31:0] F_Instr,
   output logic        F_valid,
   output logic        F_excAdEL
`ifdef F_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        exc_q, exc_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        fault_w;
   logic        consume_w;

   f_pc_addr_chk u_pc_chk (
      .addr_i  (pc_q),
      .lo_i    (PC_LO),
      .hi_i    (PC_HI),
      .fault_o (fault_w)
   );

   // A faulting PC never reaches memory; DRAIN keeps the abandoned request alive until its ack.
   always_comb begin
      im_req  = !reset && (((state_q == FETCH) && !fault_w) || pend_q);
      im_addr = pc_q;
   end

   always_comb begin
      consume_w = (state_q == HOLD) && valid_q && !D_stall;
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      exc_d     = exc_q;
      pend_d    = pend_q;
      pend_pc_d = pend_pc_q;
      case (state_q)
         FETCH: begin
            if (flush) begin
               if (im_req && !im_ack) begin
                  pend_d    = 1'b1;
                  pend_pc_d = flush_pc;
                  state_d   = DRAIN;
               end else begin
                  pc_d = flush_pc;
               end
            end else if (fault_w) begin
               instr_d = '0;
               exc_d   = 1'b1;
               valid_d = 1'b1;
               state_d = HOLD;
            end else if (im_ack) begin
               instr_d = im_rdata;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (flush) begin
               pc_d    = flush_pc;
               valid_d = 1'b0;
               exc_d   = 1'b0;
               state_d = FETCH;
            end else if (consume_w) begin
               pc_d    = F_newPC;
               valid_d = 1'b0;
               exc_d   = 1'b0;
               state_d = FETCH;
            end
         end
         DRAIN: begin
            // The most recent flush target wins, including one arriving with the ack.
            if (im_ack) begin
               pc_d    = flush ? flush_pc : pend_pc_q;
               pend_d  = 1'b0;
               state_d = FETCH;
            end else if (flush) begin
               pend_pc_d = flush_pc;
            end
         end
         default: begin
            state_d = FETCH;
            valid_d = 1'b0;
            pend_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         exc_q     <= 1'b0;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         exc_q     <= exc_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   always_comb begin
      F_PC      = pc_q;
      F_Instr   = instr_q;
      F_valid   = valid_q;
      F_excAdEL = exc_q;
   end

`ifdef F_FETCH_PERF_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if ((state_q == FETCH) && im_req && im_ack && !flush) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (valid_q && D_stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   always_comb begin
      perf_fetch_cnt = fetch_cnt_q;
      perf_stall_cnt = stall_cnt_q;
   end
`endif

endmodule
